inst_mem_arbiter: RTL and testbench

INST_MEM_ARBITER -- requirements
Module: inst_mem_arbiter

---
 rtl/inst_mem_arbiter_pkg.sv | 25 ++
 rtl/inst_mem_arbiter_rr_arb2.sv | 48 ++++
 rtl/inst_mem_arbiter.sv | 104 ++++++++++
 tb/tb_inst_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: default widths,
// requester IDs, starvation limit and the response pipeline record.
package inst_mem_arbiter_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_W     = 4;
  localparam int STARVE_LIMIT = 15;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DEBUG = 1'b1
  } port_id_e;

  typedef struct packed {
    logic     valid;
    port_id_e owner;
    logic     err;
  } rsp_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter (bit 0 = fetch, bit 1 = debug) with a debug
// lock that only holds while debug really owns the last grant, and a fetch force.
module rr_arb2
  import inst_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  input  logic       force_fetch,
  output logic [1:0] gnt
);

  port_id_e last_reg;
  logic     lock_own_reg;

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      if (force_fetch)
        gnt = 2'b01;
      else if (lock && lock_own_reg)
        gnt = 2'b10;
      else if (last_reg == PORT_FETCH)
        gnt = 2'b10;
      else
        gnt = 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Reset leaves the pointer on debug so fetch wins the first tie, but the
  // lock stays disarmed until debug has actually been granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_reg     <= PORT_DEBUG;
      lock_own_reg <= 1'b0;
    end else if (gnt[0]) begin
      last_reg     <= PORT_FETCH;
      lock_own_reg <= 1'b0;
    end else if (gnt[1]) begin
      last_reg     <= PORT_DEBUG;
      lock_own_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Arbitrates core fetch and debug/loader reads onto one synchronous-read
// instruction memory, returning data to the granted port one cycle later.
module inst_mem_arbiter
  import inst_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              f_err_o,
  input  logic              d_req_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_lock_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_ce_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_inst_i
);

  logic [1:0]          req_vec;
  logic [1:0]          gnt_vec;
  logic [STARVE_W-1:0] starve_cnt_reg;
  logic [STARVE_W-1:0] starve_cnt_next;
  logic                starve_hit;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_aligned;
  rsp_t                rsp_reg;
  rsp_t                rsp_next;
  logic [1:0]          owner_onehot;
  logic [1:0]          rvalid_vec;
  logic [1:0]          err_vec;
  logic [DATA_W-1:0]   rdata_vec [2];

  // Requests are masked during reset so no grant or memory access escapes.
  assign req_vec    = {d_req_i & rst, f_req_i & rst};
  assign starve_hit = (starve_cnt_reg == STARVE_W'(STARVE_LIMIT));

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_vec),
    .lock        (d_lock_i),
    .force_fetch (starve_hit),
    .gnt         (gnt_vec)
  );

  assign f_gnt_o = gnt_vec[0];
  assign d_gnt_o = gnt_vec[1];

  assign sel_addr    = gnt_vec[1] ? d_addr_i : f_addr_i;
  assign sel_aligned = is_aligned(sel_addr[1:0]);
  assign mem_ce_o    = (|gnt_vec) && sel_aligned;
  assign mem_addr_o  = mem_ce_o ? sel_addr : '0;

  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!f_req_i || gnt_vec[0])
      starve_cnt_next = '0;
    else if (!starve_hit)
      starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
  end

  always_comb begin
    rsp_next.valid = |gnt_vec;
    rsp_next.owner = gnt_vec[1] ? PORT_DEBUG : PORT_FETCH;
    rsp_next.err   = (|gnt_vec) && !sel_aligned;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_reg <= '0;
      rsp_reg        <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      rsp_reg        <= rsp_next;
    end
  end

  assign owner_onehot = !rsp_reg.valid ? 2'b00 :
                        (rsp_reg.owner == PORT_DEBUG) ? 2'b10 : 2'b01;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign rvalid_vec[gi] = owner_onehot[gi];
    assign err_vec[gi]    = owner_onehot[gi] & rsp_reg.err;
    assign rdata_vec[gi]  = (owner_onehot[gi] && !rsp_reg.err) ? mem_inst_i : '0;
  end

  assign f_rvalid_o = rvalid_vec[0];
  assign f_err_o    = err_vec[0];
  assign f_rdata_o  = rdata_vec[0];
  assign d_rvalid_o = rvalid_vec[1];
  assign d_err_o    = err_vec[1];
  assign d_rdata_o  = rdata_vec[1];

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench for inst_mem_arbiter: tests push expected responses at
// grant time, a negedge monitor pops and compares them the following cycle.
module tb_inst_mem_arbiter;
  import inst_mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req_i = 1'b0, d_req_i = 1'b0, d_lock_i = 1'b0;
  logic [AW-1:0] f_addr_i = '0, d_addr_i = '0;
  logic          f_gnt_o, f_rvalid_o, f_err_o, d_gnt_o, d_rvalid_o, d_err_o;
  logic [DW-1:0] f_rdata_o, d_rdata_o;
  logic          mem_ce_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_inst_i = '0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    logic          err;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [67:0] mon_got, mon_want;

  inst_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o),
    .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o), .f_err_o(f_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_lock_i(d_lock_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_inst_i(mem_inst_i)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0] + 16'h1357};
  endfunction

  // Memory model: synchronous read, garbage on idle cycles.
  always @(posedge clk) begin
    cyc++;
    mem_inst_i <= mem_ce_o ? rom_word(mem_addr_o) : $urandom();
  end

  task automatic push_exp(input logic port, input logic [AW-1:0] addr);
    exp_t e;
    e.port = port;
    e.err  = (addr[1:0] != 2'b00);
    e.data = e.err ? '0 : rom_word(addr);
    e.due  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_assert++;
      n_fail++;
      $display("FAIL rsp_missing cyc=%0d port=%0d got no response want one", cyc, exp_q[0].port);
      void'(exp_q.pop_front());
    end
    mon_got = {f_rvalid_o, f_err_o, f_rdata_o, d_rvalid_o, d_err_o, d_rdata_o};
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      mon_e = exp_q.pop_front();
      mon_want = (mon_e.port == 1'b0) ? {1'b1, mon_e.err, mon_e.data, 1'b0, 1'b0, 32'h0}
                                      : {1'b0, 1'b0, 32'h0, 1'b1, mon_e.err, mon_e.data};
      n_assert++;
      if (mon_got !== mon_want) begin
        n_fail++;
        $display("FAIL rsp cyc=%0d got %h want %h", cyc, mon_got, mon_want);
      end else begin
        $display("rsp cyc=%0d port=%0d err=%0d data=%h ok", cyc, mon_e.port, mon_e.err, mon_e.data);
      end
    end else begin
      n_assert++;
      if ({f_rvalid_o, d_rvalid_o} !== 2'b00) begin
        n_fail++;
        $display("FAIL rsp_unexpected cyc=%0d got f=%b d=%b want 0 0", cyc, f_rvalid_o, d_rvalid_o);
      end
    end
  end

  task automatic test_reset();
    f_req_i = 1'b1; f_addr_i = 32'h10;
    d_req_i = 1'b1; d_addr_i = 32'h20; d_lock_i = 1'b1;
    @(negedge clk);
    n_assert++;
    if ({f_gnt_o, d_gnt_o, f_rvalid_o, d_rvalid_o, f_err_o, d_err_o, f_rdata_o, d_rdata_o,
         mem_ce_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got gnt=%b%b ce=%b addr=%h want all 0",
               f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o);
    end else $display("reset outputs all zero");
  endtask

  task automatic test_first_grant();
    logic [34:0] want;
    next_cycle();
    rst = 1'b1; d_lock_i = 1'b0;
    f_req_i = 1'b1; f_addr_i = 32'h10; d_req_i = 1'b1; d_addr_i = 32'h20;
    @(negedge clk);
    want = {1'b1, 1'b0, 1'b1, 32'h10};
    n_assert++;
    if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
      n_fail++;
      $display("FAIL first_grant got %h want %h", {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
    end else $display("first_grant fetch ok");
    push_exp(1'b0, 32'h10);
    next_cycle();
    f_req_i = 1'b0;
    @(negedge clk);
    want = {1'b0, 1'b1, 1'b1, 32'h20};
    n_assert++;
    if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
      n_fail++;
      $display("FAIL first_grant_debug got %h want %h", {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
    end else $display("first_grant debug ok");
    push_exp(1'b1, 32'h20);
    next_cycle();
    d_req_i = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== 35'h0) begin
      n_fail++;
      $display("FAIL idle got %h want 0", {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o});
    end else $display("idle ok");
  endtask

  task automatic test_fetch_stream();
    logic [34:0] want;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      f_req_i = 1'b1; f_addr_i = 32'(4 * i); d_req_i = 1'b0;
      @(negedge clk);
      want = {1'b1, 1'b0, 1'b1, 32'(4 * i)};
      n_assert++;
      if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
        n_fail++;
        $display("FAIL fetch_stream[%0d] got %h want %h", i, {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
      end else $display("fetch_stream[%0d] addr=%h ok", i, 4 * i);
      push_exp(1'b0, 32'(4 * i));
    end
    next_cycle();
    f_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [34:0] want;
    logic [AW-1:0] fa, da;
    logic exp_f;
    next_cycle();
    d_req_i = 1'b1; d_addr_i = 32'h200; f_req_i = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({f_gnt_o, d_gnt_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL alt_setup got %b%b want 01", f_gnt_o, d_gnt_o);
    end
    push_exp(1'b1, 32'h200);
    fa = 32'h100; da = 32'h204;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      f_req_i = 1'b1; f_addr_i = fa; d_req_i = 1'b1; d_addr_i = da;
      @(negedge clk);
      exp_f = (i % 2 == 0);
      want = {exp_f, !exp_f, 1'b1, exp_f ? fa : da};
      n_assert++;
      if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
        n_fail++;
        $display("FAIL alternate[%0d] got %h want %h", i, {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
      end else $display("alternate[%0d] %s ok", i, exp_f ? "F" : "D");
      if (exp_f) begin push_exp(1'b0, fa); fa += 4; end
      else begin push_exp(1'b1, da); da += 4; end
    end
    next_cycle();
    f_req_i = 1'b0; d_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lock();
    logic [34:0] want;
    logic [AW-1:0] fa, da;
    logic exp_f;
    next_cycle();
    d_req_i = 1'b1; d_lock_i = 1'b1; d_addr_i = 32'h400; f_req_i = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({f_gnt_o, d_gnt_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_setup got %b%b want 01", f_gnt_o, d_gnt_o);
    end
    push_exp(1'b1, 32'h400);
    fa = 32'h300; da = 32'h404;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      f_req_i = 1'b1; f_addr_i = fa; d_req_i = 1'b1; d_addr_i = da; d_lock_i = 1'b1;
      @(negedge clk);
      exp_f = (i == 15);
      want = {exp_f, !exp_f, 1'b1, exp_f ? fa : da};
      n_assert++;
      if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
        n_fail++;
        $display("FAIL lock[%0d] got %h want %h", i, {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
      end else $display("lock[%0d] %s ok", i, exp_f ? "F" : "D");
      if (exp_f) begin push_exp(1'b0, fa); fa += 4; end
      else begin push_exp(1'b1, da); da += 4; end
    end
    next_cycle();
    f_req_i = 1'b0; d_req_i = 1'b0; d_lock_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    logic [34:0] want;
    next_cycle();
    f_req_i = 1'b1; f_addr_i = 32'h6;
    @(negedge clk);
    want = {1'b1, 1'b0, 1'b0, 32'h0};
    n_assert++;
    if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
      n_fail++;
      $display("FAIL misaligned_f got %h want %h", {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
    end else $display("misaligned fetch 0x6 no ce ok");
    push_exp(1'b0, 32'h6);
    next_cycle();
    f_req_i = 1'b0; d_req_i = 1'b1; d_addr_i = 32'h401;
    @(negedge clk);
    want = {1'b0, 1'b1, 1'b0, 32'h0};
    n_assert++;
    if ({f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o} !== want) begin
      n_fail++;
      $display("FAIL misaligned_d got %h want %h", {f_gnt_o, d_gnt_o, mem_ce_o, mem_addr_o}, want);
    end else $display("misaligned debug 0x401 no ce ok");
    push_exp(1'b1, 32'h401);
    next_cycle();
    d_req_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    next_cycle();
    d_req_i = 1'b1; d_addr_i = 32'h40;
    @(negedge clk);
    n_assert++;
    if ({d_gnt_o, mem_ce_o, mem_addr_o} !== {1'b1, 1'b1, 32'h40}) begin
      n_fail++;
      $display("FAIL reset_mid_grant got %b %b %h want 1 1 00000040", d_gnt_o, mem_ce_o, mem_addr_o);
    end
    next_cycle();
    rst = 1'b0; f_req_i = 1'b1; f_addr_i = 32'h50;
    @(negedge clk);
    n_assert++;
    if ({f_gnt_o, d_gnt_o, f_rvalid_o, d_rvalid_o, f_err_o, d_err_o, f_rdata_o, d_rdata_o,
         mem_ce_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got gnt=%b%b rv=%b%b ce=%b want all 0",
               f_gnt_o, d_gnt_o, f_rvalid_o, d_rvalid_o, mem_ce_o);
    end else $display("reset_mid outputs all zero");
    next_cycle();
    rst = 1'b1; f_req_i = 1'b0; d_req_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_assert++;
      if (d_rvalid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_drop[%0d] got d_rvalid=%b want 0", i, d_rvalid_o);
      end else $display("reset_mid_drop[%0d] ok", i);
      next_cycle();
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    test_reset();
    test_first_grant();
    test_fetch_stream();
    test_alternate();
    test_lock();
    test_misaligned();
    test_reset_mid();
    next_cycle();
    @(negedge clk);
    n_assert++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
